// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and state encoding for the instruction ROM loader.
package inst_rom_loader_pkg;

   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic RstEnable   = 1'b1;

   localparam logic LOAD = 1'b0;
   localparam logic RUN  = 1'b1;

   typedef enum logic {
      ST_LOAD = LOAD,
      ST_RUN  = RUN
   } state_e;

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module inst_mem_array #(
   parameter int ADDR_W = 10,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [INST_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [INST_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [INST_W-1:0] mem_q [DEPTH];

   // Boot-stream write; contents are never cleared so a partial reload keeps old words.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with boot loader: holds the core in reset while the image
// streams in, then serves zero-latency fetches.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_LOAD | accepting boot words, core held in reset, fetches return 0
//   ST_RUN  | image valid, core released, fetches served from memory
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int INST_W = InstBus
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce_i,
   input  logic [InstAddrBus-1:0] addr_i,
   output logic [INST_W-1:0]      inst_o,
   input  logic                   load_valid_i,
   input  logic [INST_W-1:0]      load_data_i,
   input  logic                   load_last_i,
   output logic                   load_ready_o,
   input  logic                   load_restart_i,
   output logic                   cpu_rst_o,
   output logic                   loaded_o,
   output logic [ADDR_W:0]        load_count_o
);

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              cpu_rst_q;
   logic              loaded_q;

   logic              xfer;
   logic              last_slot;
   logic [ADDR_W-1:0] rd_idx;
   logic              rd_in_range;
   logic              rd_en;
   logic [INST_W-1:0] rd_data;
   logic              unused_addr_lo;

   assign load_ready_o = (state_q == ST_LOAD) && (rst != RstEnable);
   assign xfer         = load_valid_i && load_ready_o;
   assign last_slot    = &ptr_q;
   assign ptr_d        = ptr_q + ADDR_W'(1);
   assign count_d      = count_q + (ADDR_W+1)'(1);

   // Load/run sequencing; leaving LOAD on the final slot is what prevents pointer wrap.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q   <= ST_LOAD;
         ptr_q     <= '0;
         count_q   <= '0;
         cpu_rst_q <= 1'b1;
         loaded_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (xfer) begin
                  ptr_q   <= ptr_d;
                  count_q <= count_d;
                  if (load_last_i || last_slot) begin
                     state_q   <= ST_RUN;
                     cpu_rst_q <= 1'b0;
                     loaded_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (load_restart_i) begin
                  state_q   <= ST_LOAD;
                  ptr_q     <= '0;
                  count_q   <= '0;
                  cpu_rst_q <= 1'b1;
                  loaded_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

   assign cpu_rst_o    = cpu_rst_q;
   assign loaded_o     = loaded_q;
   assign load_count_o = count_q;

   // Byte address to word index; any set bit above the array counts as out of range.
   assign rd_idx         = addr_i[ADDR_W+1:2];
   assign rd_in_range    = (addr_i[InstAddrBus-1:ADDR_W+2] == '0);
   assign rd_en          = (ce_i == ChipEnable) && (state_q == ST_RUN) && rd_in_range;
   assign unused_addr_lo = ^addr_i[1:0];

   inst_mem_array #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (xfer),
      .waddr_i (ptr_q),
      .wdata_i (load_data_i),
      .raddr_i (rd_idx),
      .rdata_o (rd_data)
   );

   assign inst_o = rd_en ? rd_data : INST_W'(ZeroWord);

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic        valid;
   logic [31:0] data;
   logic        last;
   logic        restart;

   logic [31:0] inst_w    [2];
   logic        ready_w   [2];
   logic        cpu_rst_w [2];
   logic        loaded_w  [2];
   logic [31:0] cnt_w     [2];
   logic [10:0] cnt_big;
   logic [2:0]  cnt_small;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model, index 0 = ADDR_W 10, index 1 = ADDR_W 2
   bit          running [2];
   int          ptr     [2];
   int          cnt     [2];
   logic [31:0] mmem    [2][1024];
   bit          wr      [2][1024];
   int          depth   [2] = '{1024, 4};

   always #5 clk = ~clk;

   inst_rom_loader #(.ADDR_W(10), .INST_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .ce_i           (ce),
      .addr_i         (addr),
      .inst_o         (inst_w[0]),
      .load_valid_i   (valid),
      .load_data_i    (data),
      .load_last_i    (last),
      .load_ready_o   (ready_w[0]),
      .load_restart_i (restart),
      .cpu_rst_o      (cpu_rst_w[0]),
      .loaded_o       (loaded_w[0]),
      .load_count_o   (cnt_big)
   );

   inst_rom_loader #(.ADDR_W(2), .INST_W(32)) dut_s (
      .clk            (clk),
      .rst            (rst),
      .ce_i           (ce),
      .addr_i         (addr),
      .inst_o         (inst_w[1]),
      .load_valid_i   (valid),
      .load_data_i    (data),
      .load_last_i    (last),
      .load_ready_o   (ready_w[1]),
      .load_restart_i (restart),
      .cpu_rst_o      (cpu_rst_w[1]),
      .loaded_o       (loaded_w[1]),
      .load_count_o   (cnt_small)
   );

   assign cnt_w[0] = {21'b0, cnt_big};
   assign cnt_w[1] = {29'b0, cnt_small};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         running[d] = 0;
         ptr[d]     = 0;
         cnt[d]     = 0;
      end
   endtask

   // One clock: check combinational outputs, take the edge, advance model, check registers.
   task automatic step();
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ready%0d", d), {31'b0, ready_w[d]}, {31'b0, (!running[d] && !rst)});
         if (ce && running[d] && addr < 32'(depth[d] * 4)) begin
            if (wr[d][addr >> 2])
               chk($sformatf("inst%0d@%h", d, addr), inst_w[d], mmem[d][addr >> 2]);
         end else begin
            chk($sformatf("inst_zero%0d@%h", d, addr), inst_w[d], 32'h0);
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            running[d] = 0; ptr[d] = 0; cnt[d] = 0;
         end else if (!running[d]) begin
            if (valid) begin
               mmem[d][ptr[d]] = data;
               wr[d][ptr[d]]   = 1;
               ptr[d]++;
               cnt[d]++;
               if (last || ptr[d] == depth[d]) running[d] = 1;
            end
         end else if (restart) begin
            running[d] = 0; ptr[d] = 0; cnt[d] = 0;
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("cpu_rst%0d", d), {31'b0, cpu_rst_w[d]}, {31'b0, !running[d]});
         chk($sformatf("loaded%0d", d), {31'b0, loaded_w[d]}, {31'b0, running[d]});
         chk($sformatf("count%0d", d), cnt_w[d], 32'(cnt[d]));
      end
   endtask

   task automatic push(input logic [31:0] w, input logic l);
      valid = 1'b1; data = w; last = l;
      step();
   endtask

   task automatic idle();
      valid = 1'b0; last = 1'b0; restart = 1'b0; rst = 1'b0;
   endtask

   task automatic fetch(input logic c, input logic [31:0] a);
      ce = c; addr = a;
      #1;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; addr = '0; valid = 1'b0; data = '0; last = 1'b0; restart = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 1024; i++) wr[d][i] = 0;
      @(posedge clk);
      #1;
      model_reset();
      step();
      chk("rst_cpu_rst", {31'b0, cpu_rst_w[0]}, 32'h1);
      chk("rst_count", cnt_w[0], 32'h0);

      // basic load
      rst = 1'b0;
      push(32'h34010001, 1'b0);
      push(32'h34020002, 1'b0);
      push(32'h00221820, 1'b1);
      idle();
      chk("basic_count", cnt_w[0], 32'd3);
      chk("basic_loaded", {31'b0, loaded_w[0]}, 32'h1);

      // fetch
      fetch(1'b1, 32'h4);
      chk("fetch4", inst_w[0], 32'h34020002);
      step();
      fetch(1'b1, 32'h7);
      chk("fetch7", inst_w[0], 32'h34020002);
      step();
      fetch(1'b0, 32'h4);
      chk("fetch_ce0", inst_w[0], 32'h0);
      step();
      fetch(1'b1, 32'h00001000);
      chk("fetch_oor", inst_w[0], 32'h0);
      step();

      // restart with simultaneous valid: no write
      fetch(1'b1, 32'h0);
      restart = 1'b1; valid = 1'b1; data = 32'h11111111;
      step();
      idle();
      chk("restart_cpu_rst", {31'b0, cpu_rst_w[0]}, 32'h1);
      chk("load_read_zero", inst_w[0], 32'h0);
      step();
      push(32'hDEADBEEF, 1'b1);
      idle();
      fetch(1'b1, 32'h0);
      chk("reload_w0", inst_w[0], 32'hDEADBEEF);
      step();
      fetch(1'b1, 32'h4);
      chk("reload_w1", inst_w[0], 32'h34020002);
      step();

      // reset mid-load
      restart = 1'b1;
      step();
      idle();
      push(32'hA0000000, 1'b0);
      push(32'hA0000001, 1'b0);
      valid = 1'b0; rst = 1'b1;
      #1;
      chk("midrst_ready", {31'b0, ready_w[0]}, 32'h0);
      step();
      idle();
      chk("midrst_count", cnt_w[0], 32'h0);
      chk("midrst_cpu_rst", {31'b0, cpu_rst_w[0]}, 32'h1);
      push(32'hB0000000, 1'b0);
      push(32'hB0000001, 1'b0);
      push(32'hB0000002, 1'b1);
      idle();
      fetch(1'b1, 32'h8);
      step();

      // full depth on the ADDR_W=2 instance
      restart = 1'b1;
      step();
      idle();
      for (int i = 0; i < 6; i++) push(32'hC0000000 + 32'(i), 1'b0);
      idle();
      chk("full_count", cnt_w[1], 32'd4);
      chk("full_loaded", {31'b0, loaded_w[1]}, 32'h1);
      fetch(1'b1, 32'hC);
      chk("full_w3", inst_w[1], 32'hC0000003);
      step();
      push(32'hC0000006, 1'b1);
      idle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst     = ($urandom_range(0, 63) == 0);
         restart = ($urandom_range(0, 15) == 0);
         valid   = ($urandom_range(0, 3) != 0);
         last    = ($urandom_range(0, 7) == 0);
         data    = $urandom;
         ce      = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0, 1: addr = 32'($urandom_range(0, 4095));
            2:    addr = 32'($urandom_range(0, 15));
            default: addr = $urandom;
         endcase
         step();
      end
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Responder side of the core's instruction-fetch interface: receives a chip-enable and byte address, returns a 32-bit instruction word in the same cycle.
- Holds the core in reset while a boot stream loads the instruction memory through a valid/ready word handshake.
- After loading, releases the core and serves fetches. Sits beside the core at top level:
  - cpu_rst_o drives the core's rst.
  - ce_i/addr_i come from the core's rom_ce_o/rom_addr_o.
  - inst_o drives the core's rom_data_i.

Parameters:
- ADDR_W, 10, word-address width; memory depth DEPTH = 2**ADDR_W words.
- INST_W, 32, instruction/word width; fixed to the core's RegBus width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- ce_i  input  1  fetch enable from core
- addr_i  input  32  fetch byte address from core
- inst_o  output  32  fetched instruction word, combinational from ce_i/addr_i/state
- load_valid_i  input  1  boot stream word valid
- load_data_i  input  32  boot stream word
- load_last_i  input  1  marks final word of boot stream; qualified by load_valid_i
- load_ready_o  output  1  block can accept a boot word this cycle
- load_restart_i  input  1  single-cycle request to re-enter LOAD from RUN
- cpu_rst_o  output  1  reset to core; high while not in RUN
- loaded_o  output  1  high in RUN (image valid)
- load_count_o  output  ADDR_W+1  words written in current/last load

Behaviour:
- States: LOAD, RUN. Single state register.
- Reset (rst high at an edge):
  - state<=LOAD, write pointer<=0, load_count_o<=0, cpu_rst_o<=1, loaded_o<=0.
  - Memory array is not cleared.
- load_ready_o = (state==LOAD) & ~rst, combinational.
  - It is 0 during the reset cycle and 1 from the first cycle after rst deasserts.
- Transfer occurs when load_valid_i & load_ready_o at an edge:
  - mem[ptr]<=load_data_i.
  - ptr<=ptr+1.
  - load_count_o<=load_count_o+1.
- LOAD->RUN happens at the transfer edge when load_last_i=1 or ptr==DEPTH-1.
  - At that same edge: loaded_o<=1, cpu_rst_o<=0.
  - The core therefore sees rst low at the next edge.
  - Writes never wrap; words beyond DEPTH are impossible because the state leaves LOAD.
- RUN->LOAD happens on an edge with load_restart_i=1.
  - ptr<=0, load_count_o<=0, cpu_rst_o<=1, loaded_o<=0.
  - Contents are retained until overwritten.
- load_restart_i in LOAD: ignored.
- load_valid_i in RUN: ignored; ready is 0, so there is no write.
- rst mid-load: the load is abandoned and restarts at word 0. Previously written words persist, but loaded_o=0.
- Fetch read:
  - Word index = addr_i[ADDR_W+1:2]. addr_i[1:0] is ignored.
  - Address bits above ADDR_W+1 being nonzero counts as out of range.
  - inst_o = mem[index] when ce_i & (state==RUN) & in-range. Otherwise inst_o = 0 (NOP).
  - Zero latency; the core registers the result in its IF/ID stage.
- No read/write collision exists, because reads return 0 in LOAD.
- Reset value of inst_o: 0 (state is LOAD).

Decomposition:
- Shared define file holds:
  - ZeroWord
  - InstBus / InstAddrBus widths
  - the ChipEnable/ChipDisable and RstEnable encodings
  - the LOAD/RUN state encodings, as 1-bit localparams or defines
- One natural sub-module: inst_mem_array. It has a single synchronous write port and one asynchronous read port, DEPTH x INST_W.
- The FSM, pointer and counter stay in the top of this block.

Test Plan:
- Basic load: after rst, stream 0x34010001, 0x34020002, 0x00221820 with last on the third word, valid held high.
  - Response: ready high 3 cycles; load_count_o=3.
  - cpu_rst_o falls and loaded_o rises at the third transfer edge.
- Fetch:
  - In RUN, ce_i=1, addr_i=0x4 -> inst_o=0x34020002 the same cycle.
  - addr_i=0x7 -> 0x34020002, since low bits are ignored.
  - ce_i=0 -> 0.
- Out of range / LOAD read:
  - addr_i=0x00001000 with ADDR_W=10 -> inst_o=0.
  - Any fetch while in LOAD -> 0.
- Full-depth: ADDR_W=2; stream 6 words with no last.
  - Only 4 are accepted; RUN is entered on the 4th edge; load_count_o=4.
  - Reading word 3 returns the 4th word.
- Restart:
  - In RUN, pulse load_restart_i together with load_valid_i.
  - Response: no write; cpu_rst_o=1 and loaded_o=0 the next cycle.
  - Reload 1 word 0xDEADBEEF -> word 0 reads 0xDEADBEEF, word 1 retains its old value.
- Reset mid-load: after 2 of 3 words, assert rst one cycle.
  - Response: load_ready_o=0 during rst, load_count_o=0 after.
  - Load resumes at word 0; cpu_rst_o stays 1 throughout.
